// File: rtl/loader_write_bridge.sv
// -----------------------------------------------------------------------------
// loader_write_bridge
//
// Purpose:
//   Buffers bytes emitted by the flash cartridge loader and replays them into
//   SDRAM, one byte per nes_ce window. The SDRAM controller shares the 2-bit
//   nes_ce phase counter; a write window opens on the clock edge where
//   nes_ce == SLOT and lasts four clocks. The request (mem_we, mem_addr,
//   mem_din) changes only on those window boundaries, so the controller sees
//   a stable request for the whole window.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..16)
//   AW     byte-address width
//   SLOT   nes_ce value that marks a window boundary
//
// Ports:
//   clock            system clock (NES domain)
//   reset_n          asynchronous active-low reset
//   load_wren        single-cycle byte strobe from the loader
//   load_address     byte address, qualified by load_wren
//   load_write_data  byte data, qualified by load_wren
//   loader_ready     loader has emitted every byte of the cartridge
//   nes_ce           free-running phase counter shared with SDRAM controller
//   mem_we           SDRAM write request
//   mem_addr         SDRAM byte address
//   mem_din          SDRAM write byte
//   load_done        cartridge fully committed to SDRAM (sticky)
//   overflow         sticky flag: a byte arrived while the FIFO was full
//   level            current FIFO occupancy
// -----------------------------------------------------------------------------
module loader_write_bridge #(
    parameter int          DEPTH = 4,
    parameter int          AW    = 22,
    parameter logic [1:0]  SLOT  = 2'd3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load_wren,
    input  logic [AW-1:0]            load_address,
    input  logic [7:0]               load_write_data,
    input  logic                     loader_ready,
    input  logic [1:0]               nes_ce,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [7:0]               mem_din,
    output logic                     load_done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LEVEL  = LW'(1);
    localparam logic [PW-1:0] ONE_PTR    = PW'(1);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_WRITE = 1'b1;

    // FIFO storage (no reset needed: emptiness is tracked by the pointers)
    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [7:0]    data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [LW-1:0] count_q,     count_d;
    logic [0:0]    state_q,     state_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]    mem_din_q,   mem_din_d;
    logic          load_done_q, load_done_d;
    logic          overflow_q,  overflow_d;

    logic boundary;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;

    // Window boundary detection and FIFO handshake. The pop decision looks
    // only at the occupancy before the edge, so a byte pushed on a boundary
    // edge waits for the following window. A pop on the same edge frees a
    // slot, which lets a push into a full FIFO succeed.
    always_comb begin
        boundary   = (nes_ce == SLOT);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_LEVEL);
        pop        = boundary && !fifo_empty;
        push       = load_wren && (!fifo_full || pop);
        drop       = load_wren && fifo_full && !pop;
    end

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + ONE_LEVEL;
            2'b01:   count_d = count_q - ONE_LEVEL;
            default: count_d = count_q;
        endcase
    end

    // Write-window FSM. Every decision happens on a boundary edge, so the
    // registered request is held for all four clocks of a window. Leaving
    // WRITE clears only mem_we; address and data keep their last values.
    always_comb begin
        state_d    = state_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        if (boundary) begin
            if (pop) begin
                state_d    = STATE_WRITE;
                mem_we_d   = 1'b1;
                mem_addr_d = addr_mem_q[rd_ptr_q];
                mem_din_d  = data_mem_q[rd_ptr_q];
            end else if (state_q == STATE_WRITE) begin
                state_d  = STATE_IDLE;
                mem_we_d = 1'b0;
            end
        end
    end

    // Sticky status flags. load_done is registered from the pre-edge
    // conditions, so it rises one clock after the last window has closed.
    always_comb begin
        load_done_d = load_done_q
                      | (loader_ready && fifo_empty && (state_q == STATE_IDLE));
        overflow_d  = overflow_q | drop;
    end

    // Control and output registers with asynchronous reset. Asserting
    // reset_n mid-window drops the request immediately and discards the
    // queued bytes by collapsing the pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= STATE_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            load_done_q <= load_done_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= load_address;
            data_mem_q[wr_ptr_q] <= load_write_data;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign load_done = load_done_q;
    assign overflow  = overflow_q;
    assign level     = count_q;

endmodule

// File: tb/tb_loader_write_bridge.sv
// -----------------------------------------------------------------------------
// tb_loader_write_bridge
//
// Directed bench for loader_write_bridge (DEPTH=4, AW=22, SLOT=3). Stimulus
// pushes the bytes it expects to reach SDRAM into a scoreboard queue; a
// monitor pops and compares whenever a write window opens, and checks that
// the request is held steady between boundaries.
// -----------------------------------------------------------------------------
module tb_loader_write_bridge;

   localparam int DEPTH = 4;
   localparam int AW    = 22;

   logic          clock;
   logic          reset_n;
   logic          load_wren;
   logic [AW-1:0] load_address;
   logic [7:0]    load_write_data;
   logic          loader_ready;
   logic [1:0]    nes_ce;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          load_done;
   logic          overflow;
   logic [2:0]    level;

   int checkCount = 0;
   int errorCount = 0;

   logic [AW+7:0] expQ[$];

   bit ceHold      = 0;
   int resetEpoch  = 0;
   int runLen      = 0;
   int burstMax    = 0;

   loader_write_bridge #(
      .DEPTH(DEPTH),
      .AW(AW),
      .SLOT(2'd3)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .load_wren(load_wren),
      .load_address(load_address),
      .load_write_data(load_write_data),
      .loader_ready(loader_ready),
      .nes_ce(nes_ce),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_din(mem_din),
      .load_done(load_done),
      .overflow(overflow),
      .level(level)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Free-running phase counter; it advances 2 units after each rising edge
   // so that at a falling edge it already shows the value the next rising
   // edge will sample. ceHold freezes it to keep boundaries away.
   initial begin
      nes_ce = 2'd0;
      forever begin
         @(posedge clock);
         #2;
         if (!ceHold) nes_ce = nes_ce + 2'd1;
      end
   end

   // Hard stop in case something never settles
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Present one byte at a falling edge for a single clock
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic [7:0] data, input bit accept);
      load_wren       = 1'b1;
      load_address    = addr;
      load_write_data = data;
      if (accept) expQ.push_back({addr, data});
      @(negedge clock);
      load_wren       = 1'b0;
      load_address    = 22'h3FFFFF;
      load_write_data = 8'hFF;
   endtask

   // Step to the falling edge where nes_ce shows the requested phase
   task automatic waitCe(input logic [1:0] value);
      bit found = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (nes_ce == value) begin
            found = 1;
            break;
         end
      end
      checkOutput("wait_phase", 32'(found), 32'd1);
   endtask

   // Wait until every expected byte has been written and the window closed
   task automatic waitDrain(input string name);
      bit done = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (runLen > burstMax) burstMax = runLen;
         if (expQ.size() == 0 && !mem_we) begin
            done = 1;
            break;
         end
      end
      checkOutput(name, 32'(done), 32'd1);
   endtask

   // Monitor: sample 1 unit after each rising edge. A boundary edge either
   // opens a window (compare against the scoreboard head) or closes one
   // (address/data must hold). Between boundaries nothing may change.
   initial begin : monitor
      logic [1:0]    ceSeen;
      logic [AW+7:0] expEntry;
      logic          holdWe;
      logic [AW-1:0] holdAddr;
      logic [7:0]    holdDin;
      int            seenEpoch;
      holdWe    = 1'b0;
      holdAddr  = '0;
      holdDin   = '0;
      seenEpoch = 0;
      forever begin
         @(posedge clock);
         ceSeen = nes_ce;
         #1;
         if (!reset_n || resetEpoch != seenEpoch) begin
            holdWe    = 1'b0;
            holdAddr  = '0;
            holdDin   = '0;
            seenEpoch = resetEpoch;
         end
         if (!reset_n) begin
            runLen = 0;
         end else begin
            if (ceSeen == 2'd3) begin
               if (mem_we) begin
                  if (expQ.size() == 0) begin
                     checkCount++;
                     errorCount++;
                     $display("[TB] FAIL stale_write: mem_we=1 addr=0x%0h din=0x%0h, required no write (t=%0t)",
                              mem_addr, mem_din, $time);
                  end else begin
                     expEntry = expQ.pop_front();
                     checkOutput("window_addr", 32'(mem_addr), 32'(expEntry[AW+7:8]));
                     checkOutput("window_din",  32'(mem_din),  32'(expEntry[7:0]));
                  end
               end else begin
                  checkOutput("close_hold_addr", 32'(mem_addr), 32'(holdAddr));
                  checkOutput("close_hold_din",  32'(mem_din),  32'(holdDin));
               end
            end else begin
               checkOutput("hold_we",   32'(mem_we),   32'(holdWe));
               checkOutput("hold_addr", 32'(mem_addr), 32'(holdAddr));
               checkOutput("hold_din",  32'(mem_din),  32'(holdDin));
            end
            holdWe   = mem_we;
            holdAddr = mem_addr;
            holdDin  = mem_din;
            if (mem_we) runLen++;
            else        runLen = 0;
         end
      end
   end

   // Directed scenarios
   initial begin : stimulus
      bit sawWrite;
      bit dropped;
      bit wrote;

      reset_n         = 1'b1;
      load_wren       = 1'b0;
      load_address    = '0;
      load_write_data = '0;
      loader_ready    = 1'b0;

      // Reset state is forced without any clock edge
      #1 reset_n = 1'b0;
      #2;
      checkOutput("reset_we",       32'(mem_we),    32'd0);
      checkOutput("reset_addr",     32'(mem_addr),  32'd0);
      checkOutput("reset_din",      32'(mem_din),   32'd0);
      checkOutput("reset_level",    32'(level),     32'd0);
      checkOutput("reset_overflow", 32'(overflow),  32'd0);
      checkOutput("reset_done",     32'(load_done), 32'd0);
      #19 reset_n = 1'b1;

      // Single byte pushed on the edge just before a boundary: mem_we one
      // clock later, held for exactly four clocks.
      $display("[TB] single byte");
      waitCe(2'd2);
      applyStimulus(22'h000010, 8'hA5, 1'b1);
      checkOutput("single_before_boundary", 32'(mem_we), 32'd0);
      checkOutput("single_level",           32'(level),  32'd1);
      @(negedge clock);
      checkOutput("single_we_rise", 32'(mem_we),   32'd1);
      checkOutput("single_addr",    32'(mem_addr), 32'h10);
      checkOutput("single_din",     32'(mem_din),  32'hA5);
      repeat (3) begin
         @(negedge clock);
         checkOutput("single_we_held", 32'(mem_we), 32'd1);
      end
      @(negedge clock);
      checkOutput("single_we_fall", 32'(mem_we),   32'd0);
      checkOutput("single_addr_kept", 32'(mem_addr), 32'h10);

      // Burst of four bytes on consecutive clocks: four back-to-back windows
      $display("[TB] burst");
      waitCe(2'd2);
      burstMax = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(22'(i), 8'(8'h11 + i), 1'b1);
         if (runLen > burstMax) burstMax = runLen;
      end
      waitDrain("burst_drain");
      checkOutput("burst_continuous_clocks", 32'(burstMax), 32'd16);

      // Byte pushed on a boundary edge into an empty FIFO waits a full window
      $display("[TB] push on boundary");
      waitCe(2'd3);
      applyStimulus(22'h000020, 8'h3C, 1'b1);
      checkOutput("late_push_no_pop", 32'(mem_we), 32'd0);
      checkOutput("late_push_level",  32'(level),  32'd1);
      repeat (3) begin
         @(negedge clock);
         checkOutput("late_push_waiting", 32'(mem_we), 32'd0);
      end
      @(negedge clock);
      checkOutput("late_push_pop", 32'(mem_we), 32'd1);
      waitDrain("late_push_drain");

      // Overflow: six bytes with the phase frozen away from the boundary
      $display("[TB] overflow");
      waitCe(2'd2);
      ceHold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(22'(22'h40 + i), 8'(8'h60 + i), (i < 4));
         if (i == 3) checkOutput("ovf_not_yet", 32'(overflow), 32'd0);
      end
      checkOutput("ovf_level", 32'(level),    32'd4);
      checkOutput("ovf_flag",  32'(overflow), 32'd1);
      ceHold = 1'b0;
      waitDrain("ovf_drain");
      checkOutput("ovf_sticky", 32'(overflow), 32'd1);
      checkOutput("ovf_empty",  32'(level),    32'd0);

      // load_done waits for the last window to close, then rises a clock later
      $display("[TB] done ordering");
      waitCe(2'd2);
      ceHold = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(22'(22'h80 + i), 8'(8'hC0 + i), 1'b1);
      loader_ready = 1'b1;
      ceHold       = 1'b0;
      sawWrite = 0;
      dropped  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (mem_we) sawWrite = 1;
         else if (sawWrite) begin
            dropped = 1;
            break;
         end
         checkOutput("done_early", 32'(load_done), 32'd0);
      end
      checkOutput("done_window_close", 32'(dropped),   32'd1);
      checkOutput("done_at_close",     32'(load_done), 32'd0);
      @(negedge clock);
      checkOutput("done_rise", 32'(load_done), 32'd1);
      applyStimulus(22'h000200, 8'h5A, 1'b1);
      waitDrain("done_late_byte_drain");
      checkOutput("done_sticky", 32'(load_done), 32'd1);

      // Asynchronous reset mid-window with two bytes still queued
      $display("[TB] async reset");
      waitCe(2'd2);
      ceHold = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(22'(22'h300 + i), 8'(8'h90 + i), 1'b1);
      ceHold = 1'b0;
      wrote = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (mem_we) begin
            wrote = 1;
            break;
         end
      end
      checkOutput("rst_window_open", 32'(wrote), 32'd1);
      checkOutput("rst_queued",      32'(level), 32'd2);
      #1;
      reset_n      = 1'b0;
      loader_ready = 1'b0;
      #1;
      checkOutput("rst_we_async",    32'(mem_we),    32'd0);
      checkOutput("rst_level_async", 32'(level),     32'd0);
      checkOutput("rst_done_async",  32'(load_done), 32'd0);
      checkOutput("rst_ovf_async",   32'(overflow),  32'd0);
      checkOutput("rst_addr_async",  32'(mem_addr),  32'd0);
      expQ.delete();
      resetEpoch++;
      #1 reset_n = 1'b1;
      repeat (12) @(negedge clock);
      checkOutput("rst_no_stale_write", 32'(mem_we), 32'd0);
      checkOutput("rst_still_empty",    32'(level),  32'd0);

      // Push into a full FIFO on the same edge as a pop: accepted, no overflow
      $display("[TB] full push and pop");
      waitCe(2'd2);
      ceHold = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(22'(22'h500 + i), 8'(8'h20 + i), 1'b1);
      checkOutput("full_level", 32'(level), 32'd4);
      ceHold = 1'b0;
      @(negedge clock);
      checkOutput("full_phase_boundary_next", 32'(nes_ce), 32'd3);
      applyStimulus(22'h000504, 8'h24, 1'b1);
      checkOutput("full_pushpop_level", 32'(level),    32'd4);
      checkOutput("full_pushpop_ovf",   32'(overflow), 32'd0);
      checkOutput("full_pushpop_we",    32'(mem_we),   32'd1);
      waitDrain("full_drain");

      // Wrap-around: 3*DEPTH+1 bytes at the sustained rate of one per window
      $display("[TB] wrap-around");
      for (int i = 0; i < 3 * DEPTH + 1; i++) begin
         applyStimulus(22'(22'h1000 + i), 8'(8'h80 + i), 1'b1);
         repeat (3) @(negedge clock);
      end
      waitDrain("wrap_drain");
      checkOutput("wrap_overflow", 32'(overflow), 32'd0);
      checkOutput("wrap_level",    32'(level),    32'd0);

      repeat (4) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/loader_write_bridge.md
LOADER_WRITE_BRIDGE -- requirements
Module: loader_write_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 22, byte-address width.
REQ-003 SHALL have parameter SLOT, default 2'd3, nes_ce value that opens an SDRAM write window.
REQ-004 SHALL have port clock  input  1  system clock (21 MHz NES domain); one clock only.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_wren  input  1  single-cycle strobe from the flash loader: byte valid.
REQ-007 SHALL have port load_address  input  AW  byte address qualified by load_wren.
REQ-008 SHALL have port load_write_data  input  8  byte qualified by load_wren.
REQ-009 SHALL have port loader_ready  input  1  flash loader cart_ready (all bytes emitted).
REQ-010 SHALL have port nes_ce  input  2  free-running phase counter shared with the SDRAM controller.
REQ-011 SHALL have port mem_we  output  1  SDRAM write request.
REQ-012 SHALL have port mem_addr  output  AW  SDRAM byte address.
REQ-013 SHALL have port mem_din  output  8  SDRAM write byte.
REQ-014 SHALL have port load_done  output  1  cartridge fully committed to SDRAM.
REQ-015 SHALL have port overflow  output  1  sticky: a byte was dropped.
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL push {load_address, load_write_data} into a DEPTH-entry FIFO on every clock where load_wren=1 and the FIFO is not full.
REQ-018 SHALL, on load_wren=1 with FIFO full and no pop in the same cycle, drop the byte, leave FIFO contents unchanged, and set overflow until reset.
REQ-019 SHALL accept push and pop in the same cycle when full; level unchanged, overflow not set.
REQ-020 SHALL implement states IDLE and WRITE, changing state only on clock edges where nes_ce==SLOT (window boundary).
REQ-021 SHALL, at a boundary in IDLE with FIFO non-empty, pop the head entry into mem_addr/mem_din, set mem_we=1, and enter WRITE.
REQ-022 SHALL, at a boundary in WRITE with FIFO non-empty, pop the next entry and stay in WRITE (back-to-back windows, mem_we stays 1).
REQ-023 SHALL, at a boundary in WRITE with FIFO empty, clear mem_we and return to IDLE; mem_addr/mem_din hold last values.
REQ-024 SHALL hold mem_we, mem_addr and mem_din constant for all 4 clocks of a window.
REQ-025 SHALL, when a byte is pushed into an empty FIFO on the same edge as a boundary, not pop it until the next boundary (pop decision uses pre-edge level).
REQ-026 SHALL give minimum latency from load_wren to mem_we=1 of 1 clock (push edge immediately before boundary) and maximum of 4 clocks with an empty FIFO and IDLE.
REQ-027 SHALL sustain one byte per 4 clocks; FIFO and pointers wrap modulo DEPTH.
REQ-028 SHALL assert load_done only when loader_ready=1, FIFO empty and state IDLE, registered (one clock after these all hold).
REQ-029 SHALL keep load_done asserted once set until reset, ignoring further load_wren (such bytes are still written).
REQ-030 SHALL ignore load_address/load_write_data when load_wren=0.

Reset
REQ-031 SHALL, while reset_n=0, force state IDLE, FIFO empty, level=0, mem_we=0, mem_addr=0, mem_din=0, load_done=0, overflow=0, independent of clock.
REQ-032 SHALL, on reset assertion mid-window, drop mem_we immediately and discard any queued bytes; operation resumes at the first boundary after reset_n rises.

Verification
REQ-033 SHALL cover single byte: load_wren at addr 0x000010, data 0xA5, nes_ce=2 -> next edge nes_ce=3 boundary, mem_we=1, mem_addr=0x000010, mem_din=0xA5 for 4 clocks, then mem_we=0.
REQ-034 SHALL cover burst: 4 bytes (0x11..0x14, addr 0..3) pushed on consecutive clocks -> four consecutive windows, mem_we continuously 1 for 16 clocks, addresses 0,1,2,3 in order.
REQ-035 SHALL cover overflow: DEPTH=4, 6 consecutive load_wren with no boundary between -> level=4, overflow=1, only first 4 bytes appear on mem_din.
REQ-036 SHALL cover done ordering: loader_ready rises while 3 bytes queued -> load_done stays 0 until the last window closes, then rises one clock later.
REQ-037 SHALL cover async reset: reset_n pulsed low mid-window with 2 bytes queued -> mem_we=0 and level=0 without a clock edge; no stale write after release.
REQ-038 SHALL cover wrap-around: 3*DEPTH+1 bytes at one byte per 4 clocks -> every byte emitted once in order, overflow=0.
